// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM encoding and
// default SRAM geometry / address map constants.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } sram_state_t;

  localparam int SRAM_AW       = 18;    // halfword address width
  localparam int SRAM_DW       = 16;    // SRAM data bus width
  localparam int DEF_BASE_ADDR = 1024;  // byte address of SRAM halfword 0
  localparam int CNT_W         = 4;     // phase counter width (WAIT_CYCLES <= 15)

endpackage

// File: rtl/sram_phase_counter.sv
// Cycle counter for one halfword phase: counts 0..WAIT_CYCLES and flags the
// terminal cycle, which is the data-hold / read-sample cycle of the phase.
module sram_phase_counter
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WAIT_CYCLES);

  // Clear wins over enable so a phase boundary always restarts at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/sram_controller.sv
// Runs a 32-bit MEM-stage load/store as two 16-bit accesses (low half, then
// high half) on an asynchronous SRAM. o_Ready drops combinationally in the
// request cycle so the pipeline freezes immediately.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = SRAM_AW,
  parameter int SRAM_DATA_WIDTH = SRAM_DW,
  parameter int WAIT_CYCLES     = 1,
  parameter int BASE_ADDR       = DEF_BASE_ADDR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_Mem_Read_Enable,
  input  logic                       i_Mem_Write_Enable,
  input  logic [DATA_WIDTH-1:0]      i_Address,
  input  logic [DATA_WIDTH-1:0]      i_Write_Data,
  output logic [DATA_WIDTH-1:0]      o_Read_Data,
  output logic                       o_Ready,
  output logic [SRAM_ADDR_WIDTH-1:0] o_Sram_Addr,
  output logic                       o_Sram_We_N,
  output logic [SRAM_DATA_WIDTH-1:0] o_Sram_Dq_Out,
  output logic                       o_Sram_Dq_Oe,
  input  logic [SRAM_DATA_WIDTH-1:0] i_Sram_Dq_In
);

  localparam int WORD_W = SRAM_ADDR_WIDTH - 1;

  sram_state_t state, state_n;

  logic                  request;
  logic                  latch;
  logic                  cnt_clear, cnt_en;
  logic [CNT_W-1:0]      cnt;
  logic                  cnt_tc;
  logic [DATA_WIDTH-1:0] offset;
  logic [WORD_W-1:0]     word_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  is_write_q;
  logic                  unused_addr_bits;

  assign request = i_Mem_Read_Enable | i_Mem_Write_Enable;

  // Unsigned subtract wraps below BASE_ADDR; byte offset and bits above the
  // SRAM word range are dropped.
  assign offset           = i_Address - DATA_WIDTH'(BASE_ADDR);
  assign unused_addr_bits = ^{offset[DATA_WIDTH-1:WORD_W+2], offset[1:0]};

  sram_phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_phase_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (cnt),
    .tc     (cnt_tc)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state, handshake and counter control
  always_comb begin
    state_n   = state;
    latch     = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    o_Ready   = 1'b0;
    case (state)
      S_IDLE: begin
        o_Ready = ~request;
        if (request) begin
          latch     = 1'b1;
          cnt_clear = 1'b1;
          state_n   = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt_tc) begin
          cnt_clear = 1'b1;
          state_n   = S_HIGH;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_tc) begin
          cnt_clear = 1'b1;
          state_n   = S_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        // DONE: one finishing cycle, never chains straight into a new access
        o_Ready = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  // SRAM pin drive; idle values match reset so an abort releases the bus at once
  always_comb begin
    o_Sram_Addr   = '0;
    o_Sram_We_N   = 1'b1;
    o_Sram_Dq_Out = '0;
    o_Sram_Dq_Oe  = 1'b0;
    if (state == S_LOW || state == S_HIGH) begin
      o_Sram_Addr = {word_q, (state == S_HIGH)};
      if (is_write_q) begin
        o_Sram_Dq_Oe  = 1'b1;
        o_Sram_Dq_Out = (state == S_HIGH) ? wdata_q[DATA_WIDTH-1:SRAM_DATA_WIDTH]
                                          : wdata_q[SRAM_DATA_WIDTH-1:0];
        // Strobe released in the last cycle so data is held past We_N rising
        o_Sram_We_N   = cnt_tc;
      end
    end
  end

  // Capture the request when leaving IDLE; write wins over read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
    end else if (latch) begin
      word_q     <= offset[WORD_W+1:2];
      wdata_q    <= i_Write_Data;
      is_write_q <= i_Mem_Write_Enable;
    end
  end

  // Load data: sample each half on the last cycle of its phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_Read_Data <= '0;
    end else if (!is_write_q && cnt_tc) begin
      if (state == S_LOW)
        o_Read_Data[SRAM_DATA_WIDTH-1:0] <= i_Sram_Dq_In;
      else if (state == S_HIGH)
        o_Read_Data[DATA_WIDTH-1:SRAM_DATA_WIDTH] <= i_Sram_Dq_In;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: bench-side SRAM model, word-level reference
// model feeding an expected-load queue, plus a WAIT_CYCLES=3 instance.
module tb_sram_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default instance (WAIT_CYCLES=1)
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata, rdata;
  logic        ready;
  logic [17:0] s_addr;
  logic        s_we_n, s_oe;
  logic [15:0] s_dq_out, s_dq_in;

  sram_controller #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset),
    .i_Mem_Read_Enable(rd_en), .i_Mem_Write_Enable(wr_en),
    .i_Address(addr), .i_Write_Data(wdata),
    .o_Read_Data(rdata), .o_Ready(ready),
    .o_Sram_Addr(s_addr), .o_Sram_We_N(s_we_n),
    .o_Sram_Dq_Out(s_dq_out), .o_Sram_Dq_Oe(s_oe),
    .i_Sram_Dq_In(s_dq_in)
  );

  // WAIT_CYCLES=3 instance
  logic        w3_rd, w3_wr;
  logic [31:0] w3_addr, w3_wdata, w3_rdata;
  logic        w3_ready;
  logic [17:0] w3_s_addr;
  logic        w3_we_n, w3_oe;
  logic [15:0] w3_dq_out, w3_dq_in;

  sram_controller #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .i_Mem_Read_Enable(w3_rd), .i_Mem_Write_Enable(w3_wr),
    .i_Address(w3_addr), .i_Write_Data(w3_wdata),
    .o_Read_Data(w3_rdata), .o_Ready(w3_ready),
    .o_Sram_Addr(w3_s_addr), .o_Sram_We_N(w3_we_n),
    .o_Sram_Dq_Out(w3_dq_out), .o_Sram_Dq_Oe(w3_oe),
    .i_Sram_Dq_In(w3_dq_in)
  );

  // Asynchronous SRAM models (halfwords 0..63), preloaded with zero
  logic [15:0] sram  [0:63];
  logic [15:0] sram3 [0:63];
  initial begin
    for (int i = 0; i < 64; i++) begin
      sram[i]  = 16'h0;
      sram3[i] = 16'h0;
    end
  end
  assign s_dq_in  = sram[s_addr[5:0]];
  assign w3_dq_in = sram3[w3_s_addr[5:0]];

  // Writes land mid-cycle while We_N is low
  always @(negedge clk) begin
    if (!s_we_n)  sram[s_addr[5:0]]     <= s_dq_out;
    if (!w3_we_n) sram3[w3_s_addr[5:0]] <= w3_dq_out;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Word-level reference model and expected-load scoreboard
  logic [31:0] model [int];
  logic [31:0] exp_q [$];

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] d;
    d = (a - 32'd1024) >> 2;
    return int'(d[16:0]);
  endfunction

  // One access on the default instance; entered just after a posedge
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
    int cyc, we_low, oe_cnt;
    bit done;
    logic [31:0] prev_rd;
    prev_rd = rdata;
    rd_en = rd; wr_en = wr; addr = a; wdata = d;
    if (wr) model[word_of(a)] = d;
    else    exp_q.push_back(model.exists(word_of(a)) ? model[word_of(a)] : 32'h0);
    @(negedge clk);
    chk({tag, "/ready_req"}, {31'h0, ready}, 32'h0);
    cyc = 0; we_low = 0; oe_cnt = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!s_we_n) we_low++;
      if (s_oe)    oe_cnt++;
      if (ready)   done = 1;
    end
    if (!done) begin
      chk({tag, "/timeout"}, 32'(cyc), 32'd5);
    end else begin
      chk({tag, "/latency"}, 32'(cyc), 32'd5);
      chk({tag, "/we_low"}, 32'(we_low), wr ? 32'd2 : 32'd0);
      chk({tag, "/oe_cycles"}, 32'(oe_cnt), wr ? 32'd4 : 32'd0);
      if (!wr) chk({tag, "/rdata"}, rdata, exp_q.pop_front());
      else     chk({tag, "/rdata_held"}, rdata, prev_rd);
    end
    rd_en = 0; wr_en = 0;
    @(posedge clk); #1;
  endtask

  // One access on the WAIT_CYCLES=3 instance; returns cycles to ready
  task automatic run3(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output int cyc);
    bit done;
    w3_rd = ~wr; w3_wr = wr; w3_addr = a; w3_wdata = d;
    cyc = 0; done = 0;
    @(negedge clk);
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (w3_ready) done = 1;
    end
    w3_rd = 0; w3_wr = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    int c3;
    reset = 1'b1;
    rd_en = 0; wr_en = 0; addr = 0; wdata = 0;
    w3_rd = 0; w3_wr = 0; w3_addr = 0; w3_wdata = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: idle after reset
    @(negedge clk);
    chk("rst/ready",  {31'h0, ready},  32'h1);
    chk("rst/we_n",   {31'h0, s_we_n}, 32'h1);
    chk("rst/oe",     {31'h0, s_oe},   32'h0);
    chk("rst/rdata",  rdata,           32'h0);
    chk("rst/addr",   {14'h0, s_addr}, 32'h0);
    chk("rst/dq_out", {16'h0, s_dq_out}, 32'h0);
    @(posedge clk); #1;

    // 2: write, then check the halfwords in the SRAM model
    run_access("wr1024", 0, 1, 32'd1024, 32'hDEADBEEF);
    chk("wr1024/hw0", {16'h0, sram[0]}, 32'h0000BEEF);
    chk("wr1024/hw1", {16'h0, sram[1]}, 32'h0000DEAD);

    // 3: read it back
    run_access("rd1024", 1, 0, 32'd1024, 32'h0);

    // 4: second word plus a preloaded neighbour
    run_access("wr1032", 0, 1, 32'd1032, 32'h12345678);
    chk("wr1032/hw4", {16'h0, sram[4]}, 32'h00005678);
    chk("wr1032/hw5", {16'h0, sram[5]}, 32'h00001234);
    run_access("rd1028", 1, 0, 32'd1028, 32'h0);
    run_access("rd1032", 1, 0, 32'd1032, 32'h0);

    // 5: read+write together is a write
    run_access("rw1036", 1, 1, 32'd1036, 32'hA5A55A5A);
    run_access("rd1036", 1, 0, 32'd1036, 32'h0);

    // byte offset bits are ignored
    run_access("rd1027", 1, 0, 32'd1027, 32'h0);

    // 6: reset during the HIGH phase of a write to 1040 (halfwords 8/9)
    wr_en = 1; addr = 32'd1040; wdata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    chk("abort/in_high_addr", {14'h0, s_addr}, 32'd9);
    reset = 1'b1; wr_en = 0;
    #1;
    chk("abort/we_n",  {31'h0, s_we_n}, 32'h1);
    chk("abort/oe",    {31'h0, s_oe},   32'h0);
    chk("abort/ready", {31'h0, ready},  32'h1);
    chk("abort/rdata", rdata,           32'h0);
    chk("abort/hw8",   {16'h0, sram[8]}, 32'h0000F00D);
    chk("abort/hw9",   {16'h0, sram[9]}, 32'h00000000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_access("post_abort_rd1032", 1, 0, 32'd1032, 32'h0);

    // WAIT_CYCLES=3 instance: latency 9 both directions, data round-trip
    run3(1, 32'd1024, 32'h0BADCAFE, c3);
    chk("w3/wr_latency", 32'(c3), 32'd9);
    chk("w3/hw0", {16'h0, sram3[0]}, 32'h0000CAFE);
    chk("w3/hw1", {16'h0, sram3[1]}, 32'h00000BAD);
    run3(0, 32'd1024, 32'h0, c3);
    chk("w3/rd_latency", 32'(c3), 32'd9);
    chk("w3/rdata", w3_rdata, 32'h0BADCAFE);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
